// File: rtl/score_counter_pkg.sv
// Shared definitions for the Dino score counter: FSM encoding, BCD widths and
// the single-digit BCD step used by every counter cell.
package score_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam int                   BCD_W     = 4;
  localparam logic [4*BCD_W-1:0]   SCORE_MAX = 16'h9999;
  localparam logic [BCD_W-1:0]     DIGIT_MAX = 4'd9;

  function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] d);
    return (d >= DIGIT_MAX) ? '0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/score_counter_bcd_digit.sv
// One BCD digit cell: clears on clr, steps on inc, and requests a carry into
// the next digit when stepping out of 9.
module bcd_digit
  import score_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  logic [BCD_W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = bcd_step(q_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc && (q_q == DIGIT_MAX);

endmodule

// File: rtl/score_counter.sv
// Dino game score counter: 4-digit BCD run score with tick prescaler, 9999
// saturation, milestone pulse and registered display mux.
// Optional high score register enabled by the SCORE_HISCORE_EN macro.
module score_counter
  import score_counter_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             crash,
  input  logic             show_hi,
  output logic [BCD_W-1:0] num3_disp,
  output logic [BCD_W-1:0] num2_disp,
  output logic [BCD_W-1:0] num1_disp,
  output logic [BCD_W-1:0] num0_disp,
  output logic             milestone,
  output logic             game_over,
  output logic             new_record
);

  localparam int              PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);

  state_e               state_q, state_d;
  logic [PW-1:0]        pre_q, pre_d;
  logic [4*BCD_W-1:0]   score, disp_q, disp_d;
  logic [3:0]           carry, digit_inc;
  logic                 enter_run, counting, tick, inc;
  logic                 milestone_q, milestone_d;
  logic                 game_over_q, game_over_d;
  logic                 unused_top_carry;

  // A crash freezes the score in the same cycle, so the prescaler and digits
  // never advance on the transition into OVER.
  always_comb begin
    enter_run = (state_q != ST_RUN) && start;
    counting  = (state_q == ST_RUN) && !crash;
    tick      = counting && (pre_q == PRE_LAST);
    inc       = tick && (score != SCORE_MAX);

    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_OVER: if (start) state_d = ST_RUN;
      ST_RUN:           if (crash) state_d = ST_OVER;
      default:          state_d = ST_IDLE;
    endcase

    pre_d = pre_q;
    if (enter_run) begin
      pre_d = '0;
    end else if (counting) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end

    milestone_d = inc && (score[2*BCD_W-1:0] == 8'h99);
    game_over_d = (state_d == ST_OVER);
  end

  assign digit_inc        = {carry[2:0], inc};
  assign unused_top_carry = carry[3];

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst   (rst),
      .clr   (enter_run),
      .inc   (digit_inc[i]),
      .q     (score[i*BCD_W +: BCD_W]),
      .carry (carry[i])
    );
  end

`ifdef SCORE_HISCORE_EN
  logic [4*BCD_W-1:0] hi_q, hi_d;
  logic               new_record_q, new_record_d;

  // Packed BCD orders the same as its decimal value, so a plain compare works.
  always_comb begin
    hi_d         = hi_q;
    new_record_d = new_record_q;
    if ((state_q == ST_RUN) && crash) begin
      if (score > hi_q) begin
        hi_d         = score;
        new_record_d = 1'b1;
      end else begin
        new_record_d = 1'b0;
      end
    end else if (enter_run) begin
      new_record_d = 1'b0;
    end
    disp_d = show_hi ? hi_q : score;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q         <= '0;
      new_record_q <= 1'b0;
    end else begin
      hi_q         <= hi_d;
      new_record_q <= new_record_d;
    end
  end

  assign new_record = new_record_q;
`else
  logic unused_show_hi;
  assign unused_show_hi = show_hi;
  assign disp_d         = score;
  assign new_record     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pre_q       <= '0;
      milestone_q <= 1'b0;
      game_over_q <= 1'b0;
      disp_q      <= '0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      milestone_q <= milestone_d;
      game_over_q <= game_over_d;
      disp_q      <= disp_d;
    end
  end

  assign num3_disp = disp_q[15:12];
  assign num2_disp = disp_q[11:8];
  assign num1_disp = disp_q[7:4];
  assign num0_disp = disp_q[3:0];
  assign milestone = milestone_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_score_counter.sv
// Testbench for score_counter with TICK_DIV=4: a cycle model pushes expected
// outputs into a queue, and each scenario task pops and compares them.
module tb_score_counter;

  localparam int TD = 4;
`ifdef SCORE_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1, start = 1'b0, crash = 1'b0, show_hi = 1'b0;
  logic [3:0] num3_disp, num2_disp, num1_disp, num0_disp;
  logic       milestone, game_over, new_record;

  score_counter #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .crash      (crash),
    .show_hi    (show_hi),
    .num3_disp  (num3_disp),
    .num2_disp  (num2_disp),
    .num1_disp  (num1_disp),
    .num0_disp  (num0_disp),
    .milestone  (milestone),
    .game_over  (game_over),
    .new_record (new_record)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] disp;
    logic        ms;
    logic        go;
    logic        nr;
  } obs_t;

  obs_t got, e;
  obs_t exp_q[$];
  assign got = {num3_disp, num2_disp, num1_disp, num0_disp, milestone, game_over, new_record};

  int errors = 0;
  int checks = 0;

  // Decimal reference model (0 idle, 1 run, 2 over)
  int   m_state = 0, m_presc = 0, m_score = 0, m_hi = 0, m_disp = 0;
  logic m_ms = 1'b0, m_go = 1'b0, m_nr = 1'b0;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic cycle(input logic r, input logic s, input logic c, input logic h);
    int   nstate, npresc, nscore, nhi, ndisp;
    logic nms, ngo, nnr;
    bit   run, inc;
    rst = r; start = s; crash = c; show_hi = h;
    @(posedge clk);
    if (r) begin
      nstate = 0; npresc = 0; nscore = 0; nhi = 0; ndisp = 0;
      nms = 1'b0; ngo = 1'b0; nnr = 1'b0;
    end else begin
      run    = (m_state == 1);
      inc    = run && !c && (m_presc == TD - 1) && (m_score < 9999);
      ndisp  = (HI_EN && h) ? m_hi : m_score;
      nms    = inc && (((m_score + 1) % 100) == 0);
      nstate = m_state; npresc = m_presc; nscore = m_score; nhi = m_hi; nnr = m_nr;
      if (run) begin
        if (c) begin
          nstate = 2;
          if (HI_EN && (m_score > m_hi)) begin
            nhi = m_score; nnr = 1'b1;
          end else begin
            nnr = 1'b0;
          end
        end else begin
          npresc = (m_presc + 1) % TD;
          if (inc) nscore = m_score + 1;
        end
      end else if (s) begin
        nstate = 1; npresc = 0; nscore = 0; nnr = 1'b0;
      end
      ngo = (nstate == 2);
    end
    m_state = nstate; m_presc = npresc; m_score = nscore; m_hi = nhi; m_disp = ndisp;
    m_ms = nms; m_go = ngo; m_nr = nnr;
    exp_q.push_back({to_bcd(ndisp), nms, ngo, nnr});
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_model got=%h exp=%h", got, e);
      end
    end
    checks++;
    if (got !== 19'h0) begin
      errors++;
      $display("FAIL reset_zero got disp=%h ms=%b go=%b nr=%b exp all zero",
               got.disp, got.ms, got.go, got.nr);
    end
  endtask

  task automatic test_count();
    int n, ms_cnt;
    logic prev_ms;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    ms_cnt = 0; prev_ms = 1'b0; n = 0;
    // 41 cycles: 40 to reach score 10, one more for the display register
    for (int i = 0; i < 41; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        if (errors < 20) $display("FAIL count_step i=%0d got=%h exp=%h", i, got, e);
      end
      if (i == 39) begin
        checks++;
        if (got.disp !== 16'h0009) begin
          errors++;
          $display("FAIL count_lag got=%h exp=0009", got.disp);
        end
      end
    end
    checks++;
    if (got.disp !== 16'h0010) begin
      errors++;
      $display("FAIL count_40 got=%h exp=0010", got.disp);
    end
    do begin
      prev_ms = got.ms;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        if (errors < 20) $display("FAIL count_to_100 got=%h exp=%h", got, e);
      end
      if (got.ms) ms_cnt++;
      n++;
    end while (got.disp !== 16'h0100 && n < 2000);
    checks++;
    if (got.disp !== 16'h0100 || !prev_ms || ms_cnt != 1) begin
      errors++;
      $display("FAIL milestone_100 disp=%h prev_ms=%b count=%0d exp 0100 1 1",
               got.disp, prev_ms, ms_cnt);
    end
    n = 0;
    do begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        if (errors < 20) $display("FAIL count_to_1000 got=%h exp=%h", got, e);
      end
      if (got.ms) ms_cnt++;
      n++;
    end while (got.disp !== 16'h1000 && n < 5000);
    checks++;
    if (got.disp !== 16'h1000 || ms_cnt != 10) begin
      errors++;
      $display("FAIL carry_1000 disp=%h ms_count=%0d exp 1000 10", got.disp, ms_cnt);
    end
  endtask

  task automatic test_crash_wins();
    int frozen, n;
    n = 0;
    while (m_presc != 1 && n < 10) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      void'(exp_q.pop_front());
      n++;
    end
    frozen = m_score;
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (got.go !== 1'b1 || got !== e) begin
      errors++;
      $display("FAIL crash_wins got=%h exp go=1 model=%h", got, e);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        if (errors < 20) $display("FAIL over_hold got=%h exp=%h", got, e);
      end
    end
    checks++;
    if (got.disp !== to_bcd(frozen)) begin
      errors++;
      $display("FAIL frozen got=%h exp=%h", got.disp, to_bcd(frozen));
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (got !== e || got.go !== 1'b0 ||
          got.disp !== ((i == 5) ? 16'h0001 : 16'h0000)) begin
        errors++;
        $display("FAIL restart i=%0d got disp=%h go=%b exp=%h", i, got.disp, got.go, e);
      end
    end
  endtask

  task automatic test_saturation();
    int n, ms_cnt;
    n = 0; ms_cnt = 0;
    do begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        if (errors < 20) $display("FAIL sat_run got=%h exp=%h", got, e);
      end
      if (got.ms) ms_cnt++;
      n++;
    end while (got.disp !== 16'h9999 && n < 45000);
    checks++;
    if (got.disp !== 16'h9999 || ms_cnt != 99) begin
      errors++;
      $display("FAIL reach_9999 disp=%h ms_count=%0d exp 9999 99", got.disp, ms_cnt);
    end
    for (int i = 0; i < 3 * TD; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (got !== e || got.disp !== 16'h9999 || got.ms !== 1'b0) begin
        errors++;
        $display("FAIL saturate got disp=%h ms=%b exp 9999 0", got.disp, got.ms);
      end
    end
  endtask

  task automatic play(input int cycles_run);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < cycles_run; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    void'(exp_q.pop_front());
  endtask

  task automatic test_hiscore();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    play(12 * TD);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (got !== e || got.disp !== 16'h0012 || got.go !== 1'b1 ||
        got.nr !== (HI_EN ? 1'b1 : 1'b0)) begin
      errors++;
      $display("FAIL hi_run1 got disp=%h go=%b nr=%b exp=%h", got.disp, got.go, got.nr, e);
    end
    play(7 * TD);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    e = exp_q.pop_front();
    checks++;
    if (got !== e || got.nr !== 1'b0 ||
        got.disp !== (HI_EN ? 16'h0012 : 16'h0007)) begin
      errors++;
      $display("FAIL hi_run2 got disp=%h nr=%b exp=%h", got.disp, got.nr, e);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (got !== e || got.disp !== 16'h0007) begin
      errors++;
      $display("FAIL live_run2 got=%h exp=0007", got.disp);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (got !== e || got !== 19'h0) begin
      errors++;
      $display("FAIL hi_reset got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_reset_midrun();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (got !== e || got !== 19'h0) begin
      errors++;
      $display("FAIL reset_midrun got=%h exp=%h", got, e);
    end
    for (int i = 0; i < 2 * TD; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (got !== e || got.disp !== 16'h0000) begin
        errors++;
        $display("FAIL idle_after_reset got=%h exp=%h", got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_crash_wins();
    test_saturation();
    test_hiscore();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
